// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline: cache-response hold, load-use bubbles,
// redirect squashing and saturating stall/bubble/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             br_redirect,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  output logic             imem_read,
  output logic             if_capture,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_load,
  output logic             id_ex_bubble,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             i_got;
  logic             d_got;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] flush_q;

  logic i_ok;
  logic d_ok;
  logic advance;
  logic hazard;
  logic redirect_case;
  logic hazard_case;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign i_ok    = imem_resp | i_got;
  assign d_ok    = ~dmem_req | dmem_resp | d_got;
  assign advance = i_ok & d_ok;

  assign hazard = ex_is_load & (ex_rd != 5'd0) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Redirect outranks the load-use hazard: the bubbled ID instruction is wrong-path anyway.
  assign redirect_case = advance & br_redirect;
  assign hazard_case   = advance & ~br_redirect & hazard;

  always_comb begin
    imem_read    = 1'b0;
    if_capture   = 1'b0;
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_load   = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_load  = 1'b0;
    mem_wb_load  = 1'b0;
    if (!rst) begin
      imem_read  = ~i_got;
      if_capture = imem_resp & ~advance;
      if (advance) begin
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
        if (br_redirect) begin
          pc_load      = 1'b1;
          if_id_load   = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (hazard) begin
          id_ex_bubble = 1'b1;
        end else begin
          pc_load    = 1'b1;
          if_id_load = 1'b1;
        end
      end
    end
  end

  assign stall_cnt  = rst ? '0 : stall_q;
  assign bubble_cnt = rst ? '0 : bubble_q;
  assign flush_cnt  = rst ? '0 : flush_q;

  // Sticky response flags remember an early response until the other side catches up.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_got    <= 1'b0;
      d_got    <= 1'b0;
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      i_got <= advance ? 1'b0 : (i_got | imem_resp);
      d_got <= advance ? 1'b0 : (d_got | (dmem_req & dmem_resp));
      if (!advance)      stall_q  <= sat_inc(stall_q);
      if (hazard_case)   bubble_q <= sat_inc(bubble_q);
      if (redirect_case) flush_q  <= sat_inc(flush_q);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the hold / redirect / load-use rules (narrow counters to reach saturation).
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // Control vector order: imem_read, if_capture, pc_load, if_id_load, if_id_flush,
  // id_ex_load, id_ex_bubble, ex_mem_load, mem_wb_load
  localparam logic [8:0] V_NORMAL   = 9'b10_1101011;
  localparam logic [8:0] V_HAZARD   = 9'b10_0001111;
  localparam logic [8:0] V_REDIRECT = 9'b10_1111111;

  logic clk = 1'b0;
  logic rst;
  logic imem_resp, dmem_req, dmem_resp, br_redirect, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_uses_rs1, id_uses_rs2;
  logic imem_read, if_capture, pc_load, if_id_load, if_id_flush;
  logic id_ex_load, id_ex_bubble, ex_mem_load, mem_wb_load;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [8:0] obs;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .br_redirect(br_redirect), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .imem_read(imem_read), .if_capture(if_capture), .pc_load(pc_load), .if_id_load(if_id_load),
    .if_id_flush(if_id_flush), .id_ex_load(id_ex_load), .id_ex_bubble(id_ex_bubble),
    .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  assign obs = {imem_read, if_capture, pc_load, if_id_load, if_id_flush,
                id_ex_load, id_ex_bubble, ex_mem_load, mem_wb_load};

  task automatic idle_inputs();
    imem_resp = 0; dmem_req = 0; dmem_resp = 0; br_redirect = 0; ex_is_load = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; imem_resp = 1; dmem_req = 1; dmem_resp = 1; br_redirect = 1;
    tick(); tick();
    @(negedge clk);
    compared++;
    if (obs !== 9'b0) begin
      mismatched++; $display("FAIL reset_ctrl got=%b want=%b", obs, 9'b0);
    end
    compared++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) begin
      mismatched++; $display("FAIL reset_cnt got=%0d/%0d/%0d want=0/0/0", stall_cnt, bubble_cnt, flush_cnt);
    end
    tick(); rst = 0; idle_inputs();
  endtask

  task automatic test_stream();
    do_reset();
    imem_resp = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if (obs !== V_NORMAL) begin
        mismatched++; $display("FAIL stream_ctrl c%0d got=%b want=%b", i, obs, V_NORMAL);
      end
      tick();
    end
    @(negedge clk);
    compared++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) begin
      mismatched++; $display("FAIL stream_cnt got=%0d/%0d/%0d want=0/0/0", stall_cnt, bubble_cnt, flush_cnt);
    end
  endtask

  task automatic test_split();
    logic [8:0] want;
    do_reset();
    dmem_req = 1;
    for (int c = 0; c <= 5; c++) begin
      imem_resp = (c == 2);
      dmem_resp = (c == 5);
      case (c)
        0, 1:    want = 9'b10_0000000;
        2:       want = 9'b11_0000000;
        3, 4:    want = 9'b00_0000000;
        default: want = 9'b00_1101011;
      endcase
      @(negedge clk);
      compared++;
      if (obs !== want) begin
        mismatched++; $display("FAIL split_ctrl c%0d got=%b want=%b", c, obs, want);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    compared++;
    if (stall_cnt !== 4'd5 || imem_read !== 1'b1) begin
      mismatched++; $display("FAIL split_after stall=%0d imem_read=%b want 5/1", stall_cnt, imem_read);
    end
  endtask

  task automatic test_load_use(input logic redirect);
    logic [8:0] want;
    do_reset();
    imem_resp = 1; ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    id_rs1 = 3; id_uses_rs1 = 1; br_redirect = redirect;
    want = redirect ? V_REDIRECT : V_HAZARD;
    @(negedge clk);
    compared++;
    if (obs !== want) begin
      mismatched++; $display("FAIL loaduse_ctrl redirect=%b got=%b want=%b", redirect, obs, want);
    end
    tick();
    idle_inputs(); imem_resp = 1;
    @(negedge clk);
    compared++;
    if (bubble_cnt !== (redirect ? 4'd0 : 4'd1) || flush_cnt !== (redirect ? 4'd1 : 4'd0)) begin
      mismatched++; $display("FAIL loaduse_cnt redirect=%b got b=%0d f=%0d want b=%0d f=%0d",
                             redirect, bubble_cnt, flush_cnt, !redirect, redirect);
    end
  endtask

  task automatic test_x0();
    do_reset();
    imem_resp = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; id_rs2 = 0; id_uses_rs2 = 1;
    @(negedge clk);
    compared++;
    if (obs !== V_NORMAL) begin
      mismatched++; $display("FAIL x0_ctrl got=%b want=%b", obs, V_NORMAL);
    end
    tick();
    @(negedge clk);
    compared++;
    if (bubble_cnt !== 4'd0) begin
      mismatched++; $display("FAIL x0_cnt got=%0d want=0", bubble_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    dmem_req = 1; imem_resp = 1;
    tick();
    imem_resp = 0;
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    compared++;
    if (stall_cnt !== 4'd7 || imem_read !== 1'b0) begin
      mismatched++; $display("FAIL midstall_pre stall=%0d imem_read=%b want 7/0", stall_cnt, imem_read);
    end
    rst = 1;
    @(negedge clk);
    compared++;
    if (obs !== 9'b0 || stall_cnt !== 4'd0) begin
      mismatched++; $display("FAIL midstall_rst ctrl=%b stall=%0d want 0/0", obs, stall_cnt);
    end
    tick();
    rst = 0; idle_inputs();
    @(negedge clk);
    compared++;
    if (obs !== 9'b10_0000000 || stall_cnt !== 4'd0) begin
      mismatched++; $display("FAIL midstall_post ctrl=%b stall=%0d want %b/0", obs, stall_cnt, 9'b10_0000000);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    imem_resp = 1; br_redirect = 1;
    for (int i = 0; i < 18; i++) tick();
    @(negedge clk);
    compared++;
    if (stall_cnt !== 4'(CMAX) || flush_cnt !== 4'(CMAX)) begin
      mismatched++; $display("FAIL saturation stall=%0d flush=%0d want %0d/%0d", stall_cnt, flush_cnt, CMAX, CMAX);
    end
  endtask

  task automatic test_random();
    bit m_ifetched, m_ddone, adv, haz;
    int m_stall, m_bubble, m_flush;
    logic [8:0] want;
    logic [3*CNT_W-1:0] want_cnt;
    do_reset();
    m_ifetched = 0; m_ddone = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 40) == 0);
      imem_resp = ($urandom_range(0, 2) == 0);
      dmem_req = $urandom_range(0, 1);
      dmem_resp = ($urandom_range(0, 2) == 0);
      br_redirect = ($urandom_range(0, 5) == 0);
      ex_is_load = $urandom_range(0, 1);
      ex_rd = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_uses_rs1 = $urandom_range(0, 1);
      id_uses_rs2 = $urandom_range(0, 1);
      @(negedge clk);
      adv = (imem_resp || m_ifetched) && (!dmem_req || dmem_resp || m_ddone);
      haz = ex_is_load && ex_rd != 0 &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (rst)              want = 9'b0;
      else if (!adv)        want = {!m_ifetched, imem_resp, 7'b0};
      else if (br_redirect) want = V_REDIRECT & {!m_ifetched, 8'hFF};
      else if (haz)         want = V_HAZARD & {!m_ifetched, 8'hFF};
      else                  want = V_NORMAL & {!m_ifetched, 8'hFF};
      want_cnt = rst ? '0 : {4'(m_stall), 4'(m_bubble), 4'(m_flush)};
      compared++;
      if (obs !== want) begin
        mismatched++; $display("FAIL random_ctrl n=%0d got=%b want=%b", n, obs, want);
      end
      compared++;
      if ({stall_cnt, bubble_cnt, flush_cnt} !== want_cnt) begin
        mismatched++; $display("FAIL random_cnt n=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", n,
                               stall_cnt, bubble_cnt, flush_cnt, want_cnt[11:8], want_cnt[7:4], want_cnt[3:0]);
      end
      if (rst) begin
        m_ifetched = 0; m_ddone = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
      end else if (adv) begin
        m_ifetched = 0; m_ddone = 0;
        if (br_redirect) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (haz)    m_bubble = (m_bubble < CMAX) ? m_bubble + 1 : CMAX;
      end else begin
        m_ifetched = m_ifetched || imem_resp;
        m_ddone = m_ddone || (dmem_req && dmem_resp);
        m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
      tick();
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_stream();
    test_split();
    test_load_use(1'b0);
    test_load_use(1'b1);
    test_x0();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
